// File: rtl/imem_boot_loader.sv
// Boot loader: turns a little-endian byte stream (16-bit word count, then the words) into
// instruction-memory writes, and keeps the core in reset until the whole image is written.
module imem_boot_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic        start,
    output logic        imem_we,
    output logic [31:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);
    // state   | meaning
    // CNT_LO  | waiting for low byte of word count
    // CNT_HI  | waiting for high byte of word count, then validate it
    // DATA    | assembling words and issuing write strobes
    // DONE    | image written, core released
    // ERR     | bad header, core held in reset until start/reset
    localparam int WIDX_W = $clog2(DEPTH_WORDS) + 1;

    typedef enum logic [2:0] {
        S_CNT_LO,
        S_CNT_HI,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [15:0]        count;
    logic [1:0]         byte_idx;
    logic [WIDX_W-1:0]  word_idx;
    logic [23:0]        word_buf;

    logic               xfer;
    logic [15:0]        full_count;
    logic               bad_count;
    logic               last_word;

    assign byte_ready = (state == S_CNT_LO) || (state == S_CNT_HI) || (state == S_DATA);
    assign xfer       = byte_valid && byte_ready;
    assign full_count = {byte_data, count[7:0]};
    assign bad_count  = (full_count == 16'd0) || (32'(full_count) > 32'(DEPTH_WORDS));
    assign last_word  = (32'(word_idx) + 32'd1) == 32'(count);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_CNT_LO;
            count      <= '0;
            byte_idx   <= '0;
            word_idx   <= '0;
            word_buf   <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_CNT_LO: begin
                    if (xfer) begin
                        count[7:0] <= byte_data;
                        state      <= S_CNT_HI;
                    end
                end
                S_CNT_HI: begin
                    if (xfer) begin
                        count[15:8] <= byte_data;
                        if (bad_count) begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= byte_data;
                            2'd1: word_buf[15:8]  <= byte_data;
                            2'd2: word_buf[23:16] <= byte_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_waddr <= BASE_ADDR + (32'(word_idx) << 2);
                                imem_wdata <= {byte_data, word_buf};
                                word_idx   <= word_idx + 1'b1;
                                if (last_word) begin
                                    state <= S_DONE;
                                end
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    // Release lands one cycle after the final strobe.
                    cpu_reset <= 1'b0;
                    done      <= 1'b1;
                    if (start) begin
                        state     <= S_CNT_LO;
                        cpu_reset <= 1'b1;
                        done      <= 1'b0;
                        count     <= '0;
                        byte_idx  <= '0;
                        word_idx  <= '0;
                        word_buf  <= '0;
                    end
                end
                S_ERR: begin
                    cpu_reset <= 1'b1;
                    if (start) begin
                        state    <= S_CNT_LO;
                        error    <= 1'b0;
                        count    <= '0;
                        byte_idx <= '0;
                        word_idx <= '0;
                        word_buf <= '0;
                    end
                end
                default: state <= S_CNT_LO;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a cycle-by-cycle vector table plus
// hand-written sequences for gapped streams and a full-depth image.
module tb_imem_boot_loader;
    logic        clock;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        start;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    imem_boot_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        v;
        logic        st;
        logic [7:0]  d;
        logic        ready;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        cr;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t        tbl[$];
    int          checks = 0;
    int          errors = 0;
    int          n_acc = 0;
    bit          mon_on = 1'b0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic rst, input logic v, input logic st, input logic [7:0] d,
                       input logic ready, input logic we, input logic [31:0] addr,
                       input logic [31:0] data, input logic cr, input logic dn, input logic er);
        vec_t r;
        r = '{rst, v, st, d, ready, we, addr, data, cr, dn, er};
        tbl.push_back(r);
    endtask

    task automatic send_byte(input logic [7:0] d, input int max_gap, output bit accepted);
        int gap;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        byte_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        byte_valid = 1'b1;
        byte_data  = d;
        accepted   = byte_ready;
        step();
        byte_valid = 1'b0;
        if (accepted) n_acc++;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) step();
    endtask

    // Every strobe must follow exactly the 4th data byte of its word (2 header bytes first).
    always @(negedge clock) begin
        if (mon_on && imem_we) begin
            wr_addr_q.push_back(imem_waddr);
            wr_data_q.push_back(imem_wdata);
            chk("strobe_timing", 69'(n_acc), 69'(2 + 4 * wr_addr_q.size()));
        end
    end

    initial begin
        logic [7:0]  img1[10];
        logic [31:0] exp_w;
        bit          acc;
        int          bad;

        img1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};

        //   rst v  st d       ready we addr    data          cr dn er
        add(0, 1, 0, 8'h02, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h13, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h05, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h10, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 1, 32'h0, 32'h00100513, 1, 0, 0);
        add(0, 1, 0, 8'h93, 1, 0, 32'h0, 32'h00100513, 1, 0, 0);
        add(0, 1, 0, 8'h05, 1, 0, 32'h0, 32'h00100513, 1, 0, 0);
        add(0, 1, 0, 8'h20, 1, 0, 32'h0, 32'h00100513, 1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 1, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 32'h4, 32'h00200593, 0, 1, 0);
        add(0, 1, 0, 8'hAA, 0, 0, 32'h4, 32'h00200593, 0, 1, 0);
        add(0, 0, 1, 8'h00, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 0, 8'h01, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 0, 8'hEF, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 0, 8'hBE, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 1, 8'hAD, 1, 0, 32'h4, 32'h00200593, 1, 0, 0);
        add(0, 1, 0, 8'hDE, 0, 1, 32'h0, 32'hDEADBEEF, 1, 0, 0);
        add(0, 0, 0, 8'h00, 0, 0, 32'h0, 32'hDEADBEEF, 0, 1, 0);
        add(1, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h00, 0, 0, 32'h0, 32'h0,        1, 0, 1);
        add(0, 1, 0, 8'h55, 0, 0, 32'h0, 32'h0,        1, 0, 1);
        add(0, 0, 1, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h01, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h01, 0, 0, 32'h0, 32'h0,        1, 0, 1);
        add(0, 0, 0, 8'h00, 0, 0, 32'h0, 32'h0,        1, 0, 1);
        add(1, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h01, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h11, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(0, 1, 0, 8'h22, 1, 0, 32'h0, 32'h0,        1, 0, 0);
        add(1, 0, 0, 8'h00, 1, 0, 32'h0, 32'h0,        1, 0, 0);

        reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; start = 1'b0;
        step(); step();
        chk("reset_state", {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error},
            {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0});

        foreach (tbl[i]) begin
            reset      = tbl[i].rst;
            byte_valid = tbl[i].v;
            byte_data  = tbl[i].d;
            start      = tbl[i].st;
            step();
            chk($sformatf("vec%0d", i),
                {byte_ready, imem_we, imem_waddr, imem_wdata, cpu_reset, done, error},
                {tbl[i].ready, tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].cr, tbl[i].dn, tbl[i].er});
        end
        reset = 1'b0; byte_valid = 1'b0; start = 1'b0;

        // Image 1 again after mid-load reset, with random gaps between bytes.
        mon_on = 1'b1;
        n_acc = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        foreach (img1[i]) send_byte(img1[i], 3, acc);
        wait_done(8);
        chk("gap_done", {done, cpu_reset, byte_ready}, {1'b1, 1'b0, 1'b0});
        chk("gap_nwrites", 69'(wr_addr_q.size()), 69'd2);
        if (wr_addr_q.size() == 2) begin
            chk("gap_w0", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h00100513});
            chk("gap_w1", {wr_addr_q[1], wr_data_q[1]}, {32'h4, 32'h00200593});
        end

        // Full-depth image of 256 words, streamed back to back.
        start = 1'b1; step(); start = 1'b0;
        chk("restart", {byte_ready, cpu_reset, done}, {1'b1, 1'b1, 1'b0});
        n_acc = 0;
        wr_addr_q.delete(); wr_data_q.delete();
        send_byte(8'h00, 0, acc);
        send_byte(8'h01, 0, acc);
        for (int k = 0; k < 1024; k++) send_byte(8'(k * 7 + 3), 0, acc);
        wait_done(8);
        chk("full_nwrites", 69'(wr_addr_q.size()), 69'd256);
        bad = 0;
        for (int j = 0; j < wr_addr_q.size(); j++) begin
            exp_w = {8'((4*j+3) * 7 + 3), 8'((4*j+2) * 7 + 3), 8'((4*j+1) * 7 + 3), 8'((4*j) * 7 + 3)};
            if (wr_addr_q[j] !== 32'(4 * j) || wr_data_q[j] !== exp_w) bad++;
        end
        chk("full_contents", 69'(bad), 69'd0);
        if (wr_addr_q.size() > 0) chk("full_last_addr", 69'(wr_addr_q[$]), 69'h3FC);
        chk("full_done", {done, cpu_reset, error}, {1'b1, 1'b0, 1'b0});
        send_byte(8'hFF, 0, acc);
        chk("byte_1025_refused", {69'(acc), 69'(byte_ready)}, 138'd0);
        chk("no_write_after_done", 69'(wr_addr_q.size()), 69'd256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
